// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with an internal round-robin / fixed-priority arbiter
// and a single valid/ready output stage.
module rr_mux_arb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*W-1:0]     in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [$clog2(N)-1:0] out_sel,
    input  logic               out_ready
);
    localparam int unsigned SW = $clog2(N);

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load;
    logic          any_req;
    logic          transfer;
    logic [SW-1:0] grant;
    logic [W-1:0]  grant_data;

    assign load     = !out_valid_q || out_ready;
    assign any_req  = |in_valid;
    assign transfer = load && any_req && !rst;

    // Descending scans so the lowest matching index wins; in round-robin the
    // second scan (k >= ptr) overrides the wrapped-around first scan (k < ptr).
    always_comb begin
        grant = '0;
        if (mode) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[k]) grant = SW'(k);
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[k] && k < int'(ptr_q)) grant = SW'(k);
            end
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[k] && k >= int'(ptr_q)) grant = SW'(k);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SW'(k)) begin
                grant_data  = in_data[k*W +: W];
                in_ready[k] = transfer;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any_req;
        end
        if (transfer) begin
            out_data_d = grant_data;
            out_sel_d  = grant;
            if (!mode) begin
                ptr_d = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: directed stimulus pushes expected words, a negedge
// monitor pops and compares each word as the output handshake completes.
module tb_rr_mux_arb;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    rr_mux_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive just after the edge, check in_ready mid-cycle and
    // queue the word that the hand-computed grant should deliver.
    task automatic step(input logic [3:0] v, input logic m, input logic r,
                        input logic [3:0] exp_rdy, input string name);
        @(posedge clk);
        #1;
        in_valid  = v;
        mode      = m;
        out_ready = r;
        #3;
        check(name, 16'(in_ready), 16'(exp_rdy));
        for (int k = 0; k < N; k++) begin
            if (exp_rdy[k]) exp_q.push_back({2'(k), 8'(8'hA0 + k)});
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got sel=%0d data=%h expected no word", out_sel,
                         out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("mon_sel", 16'(out_sel), 16'(e[9:8]));
                check("mon_data", 16'(out_data), 16'(e[7:0]));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #2;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_data", 16'(out_data), 16'h0);
        check("rst_out_sel", 16'(out_sel), 16'h0);
        check("rst_in_ready", 16'(in_ready), 16'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 4'b0000;

        // Round-robin fairness
        step(4'b1111, 1'b0, 1'b1, 4'b0001, "rr_0");
        step(4'b1111, 1'b0, 1'b1, 4'b0010, "rr_1");
        step(4'b1111, 1'b0, 1'b1, 4'b0100, "rr_2");
        step(4'b1111, 1'b0, 1'b1, 4'b1000, "rr_3");
        step(4'b1111, 1'b0, 1'b1, 4'b0001, "rr_4");
        step(4'b1111, 1'b0, 1'b1, 4'b0010, "rr_5");

        // Fixed priority, ptr left at 2, then back to round-robin
        step(4'b0110, 1'b1, 1'b1, 4'b0010, "fp_0");
        step(4'b0110, 1'b1, 1'b1, 4'b0010, "fp_1");
        step(4'b0110, 1'b1, 1'b1, 4'b0010, "fp_2");
        step(4'b0110, 1'b0, 1'b1, 4'b0100, "mode_sw_rr");

        // Backpressure holds the channel-2 word
        for (int i = 0; i < 3; i++) begin
            step(4'b0110, 1'b0, 1'b0, 4'b0000, "bp_ready");
            check("bp_valid", 16'(out_valid), 16'h1);
            check("bp_sel", 16'(out_sel), 16'h2);
            check("bp_data", 16'(out_data), 16'hA2);
        end
        step(4'b0110, 1'b0, 1'b1, 4'b0010, "bp_release");

        // Wrap and sparse requests
        step(4'b0100, 1'b0, 1'b1, 4'b0100, "wrap_ptr3");
        step(4'b0001, 1'b0, 1'b1, 4'b0001, "wrap_g0");
        step(4'b1000, 1'b0, 1'b1, 4'b1000, "wrap_g3");
        step(4'b1111, 1'b0, 1'b1, 4'b0001, "wrap_ptr0");

        // Drain after a single channel-2 request
        step(4'b0100, 1'b0, 1'b1, 4'b0100, "drain_req");
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "drain_idle0");
        check("drain_valid_hi", 16'(out_valid), 16'h1);
        check("drain_sel_hi", 16'(out_sel), 16'h2);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "drain_idle1");
        check("drain_valid_lo", 16'(out_valid), 16'h0);
        check("drain_sel_keep", 16'(out_sel), 16'h2);
        check("drain_data_keep", 16'(out_data), 16'hA2);

        // Mid-stream asynchronous reset with a held word and ptr=3
        step(4'b0100, 1'b0, 1'b1, 4'b0100, "mr_load");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, "mr_hold");
        check("mr_held_valid", 16'(out_valid), 16'h1);
        #2;
        in_valid = 4'b1111;
        rst      = 1'b1;
        #1;
        check("mr_out_valid", 16'(out_valid), 16'h0);
        check("mr_out_data", 16'(out_data), 16'h0);
        check("mr_out_sel", 16'(out_sel), 16'h0);
        check("mr_in_ready", 16'(in_ready), 16'h0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 4'b0000;
        step(4'b1010, 1'b0, 1'b1, 4'b0010, "mr_ptr0");
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "tail_0");
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "tail_1");
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
